ldpc_addr_gen: RTL and testbench
================================

Name: ldpc_addr_gen

Overview:
- Read-address sequencer that sits directly upstream of ldpc_ram.
- Walks a quasi-cyclic parity-check base matrix layer by layer and row by row. Emits one variable-node RAM address per nonzero circulant entry, over a valid/ready handshake, into the RAM's output-address port.
- The base-matrix description is held in an internal schedule table, loaded through a write port before decoding starts.

Parameters:
- Z, 64, circulant (lifting) size; any integer >= 2, not necessarily a power of 2.
- COLS, 24, number of base-matrix columns; RAM depth is COLS*Z.
- MAX_ENTRIES, 32, schedule table depth (total nonzero base-matrix entries).
- ADDR_W, $clog2(COLS*Z), output address width; matches the ldpc_ram address width.

Ports:
- i_clock, in, 1, single clock.
- i_reset, in, 1, asynchronous, active-high reset.
- i_tbl_wr, in, 1, schedule table write strobe.
- i_tbl_idx, in, $clog2(MAX_ENTRIES), table write index.
- i_tbl_col, in, $clog2(COLS), base column of the entry.
- i_tbl_shift, in, $clog2(Z), circulant shift, 0..Z-1.
- i_tbl_last, in, 1, entry is the last one of its layer.
- i_num_entries, in, $clog2(MAX_ENTRIES)+1, entries used; sampled when a start is accepted.
- i_start, in, 1, start-of-walk request.
- o_busy, out, 1, high from start acceptance until the o_done cycle, inclusive.
- o_addr, out, ADDR_W, RAM read address.
- o_addr_valid, out, 1, o_addr is valid.
- i_addr_ready, in, 1, downstream accepts o_addr.
- o_row_last, out, 1, qualifies o_addr: last address of the current check row.
- o_done, out, 1, one-cycle pulse after the final address is accepted.

Behaviour:
- Reset values: o_addr=0, o_addr_valid=0, o_row_last=0, o_done=0, o_busy=0, FSM=IDLE.
- Table contents are not reset.
- Table:
  - Written synchronously when i_tbl_wr=1.
  - Writes while o_busy=1 are ignored.
  - Reads are asynchronous (distributed RAM).
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - i_start=1 latches i_num_entries and sets o_busy=1.
  - Counters clear: entry idx e=0, layer base b=0, row z=0.
  - If the latched count is 0, go to DONE.
  - Otherwise go to RUN and present the first address on the next cycle (1-cycle start-to-valid latency).
  - i_start is ignored outside IDLE.
- Address formula:
  - o_addr = col[e]*Z + m, where m = z+shift[e] if that sum < Z, else z+shift[e]-Z.
  - All arithmetic is done at ADDR_W+1 bits, with no truncation before the final assignment.
- Walk order: layers in table order. Within a layer, z runs 0..Z-1; for each z, entries run from b to the layer end.
  - The layer end is the first entry with last=1, or entry num_entries-1, whichever comes first.
- Advance on o_addr_valid & i_addr_ready. Each step applies exactly one of the following, taking the first case that matches:
  - Not at layer end: e++.
  - At layer end and z<Z-1: z++, e=b.
  - At layer end and z=Z-1, not the final entry: b=e+1, e=e+1, z=0.
  - At layer end, z=Z-1, final entry (e=num_entries-1): drop o_addr_valid, go to DONE.
- o_row_last=1 exactly when e is the layer end.
- Backpressure: while o_addr_valid=1 and i_addr_ready=0, o_addr and o_row_last hold stable.
- o_addr_valid never deasserts in RUN except after the final accept.
- Outputs are registered; no combinational path from i_addr_ready to o_addr or o_addr_valid.
- DONE: assert o_done for one cycle, clear o_busy in the following cycle, return to IDLE.
  - A new i_start is accepted on the cycle after DONE.
- Asynchronous reset mid-walk forces IDLE immediately. Outputs go to their reset values and no o_done is issued.
- An entry with last=0 at index num_entries-1 still terminates the walk.
- Total addresses per walk = Z * num_entries.

Test Plan:
- Z=4, COLS=4; table e0={col1,sh1,last0}, e1={col3,sh0,last1}, e2={col0,sh3,last1}; num=3; ready held high.
  - Required sequence: 5,12,6,13,7,14,4,15,3,0,1,2.
  - o_row_last=1 on 12,13,14,15,3,0,1,2.
  - o_done one cycle after the address 2 handshake; o_addr_valid first high 1 cycle after i_start.
- Same setup with ready toggled 1,0,0,1 repeating → identical sequence; o_addr stable during every stall; no duplicated or dropped address.
- Z=3 (non-power-of-2), single entry {col2,sh2,last1}, num=1 → 8,6,7, each with o_row_last=1, then o_done.
- num_entries=0 → no o_addr_valid; o_done pulses 2 cycles after i_start.
- Reset during the 5th address of the first test → all outputs 0 asynchronously, no o_done. Restarting yields the full 12-address sequence.
- Table write and i_start issued mid-walk → both ignored; walk output unchanged; the rewritten entry takes effect only when written after o_busy=0.

Source files
------------

// File: rtl/ldpc_addr_gen.sv
// Read-address sequencer for ldpc_ram: walks a quasi-cyclic base matrix layer by layer,
// row by row, emitting one variable-node address per nonzero circulant over valid/ready.
module ldpc_addr_gen #(
  parameter int Z           = 64,
  parameter int COLS        = 24,
  parameter int MAX_ENTRIES = 32,
  parameter int ADDR_W      = $clog2(COLS * Z)
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_tbl_wr,
  input  logic [$clog2(MAX_ENTRIES)-1:0] i_tbl_idx,
  input  logic [$clog2(COLS)-1:0]        i_tbl_col,
  input  logic [$clog2(Z)-1:0]           i_tbl_shift,
  input  logic                           i_tbl_last,
  input  logic [$clog2(MAX_ENTRIES):0]   i_num_entries,
  input  logic                           i_start,
  output logic                           o_busy,
  output logic [ADDR_W-1:0]              o_addr,
  output logic                           o_addr_valid,
  input  logic                           i_addr_ready,
  output logic                           o_row_last,
  output logic                           o_done
);

  localparam int IW  = $clog2(MAX_ENTRIES);
  localparam int CW  = $clog2(COLS);
  localparam int ZW  = $clog2(Z);
  localparam int AW1 = ADDR_W + 1;

  localparam logic [AW1-1:0] Z_A    = AW1'(Z);
  localparam logic [ZW-1:0]  Z_LAST = ZW'(Z - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Handshake: a transfer happens on a rising clock edge where o_addr_valid and
  // i_addr_ready are both high; while valid is high and ready is low, o_addr and
  // o_row_last hold, and valid only falls after the final transfer.

  logic [CW-1:0] tbl_col_q   [MAX_ENTRIES];
  logic [ZW-1:0] tbl_shift_q [MAX_ENTRIES];
  logic          tbl_last_q  [MAX_ENTRIES];

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     e_q, e_d;
  logic [IW-1:0]     b_q, b_d;
  logic [ZW-1:0]     z_q, z_d;
  logic [IW:0]       num_q, num_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              row_last_q, row_last_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              load;
  logic              final_e;
  logic              at_end;

  // Table is plain storage with no reset; frozen while a walk is in flight.
  always_ff @(posedge i_clock) begin
    if (i_tbl_wr && !busy_q) begin
      tbl_col_q[i_tbl_idx]   <= i_tbl_col;
      tbl_shift_q[i_tbl_idx] <= i_tbl_shift;
      tbl_last_q[i_tbl_idx]  <= i_tbl_last;
    end
  end

  function automatic logic is_final(input logic [IW-1:0] e, input logic [IW:0] n);
    return ({1'b0, e} + (IW + 1)'(1)) == n;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IW-1:0] e,
                                                input logic [ZW-1:0] z);
    logic [AW1-1:0] m;
    logic [AW1-1:0] base;
    m = AW1'(z) + AW1'(tbl_shift_q[e]);
    if (m >= Z_A) m = m - Z_A;
    base = AW1'(tbl_col_q[e]) * Z_A;
    return ADDR_W'(base + m);
  endfunction

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    b_d     = b_q;
    z_d     = z_q;
    num_d   = num_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    load    = 1'b0;
    final_e = is_final(e_q, num_q);
    at_end  = tbl_last_q[e_q] || final_e;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          num_d  = i_num_entries;
          busy_d = 1'b1;
          e_d    = '0;
          b_d    = '0;
          z_d    = '0;
          if (i_num_entries == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            load    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (valid_q && i_addr_ready) begin
          if (!at_end) begin
            e_d  = e_q + IW'(1);
            load = 1'b1;
          end else if (z_q != Z_LAST) begin
            z_d  = z_q + ZW'(1);
            e_d  = b_q;
            load = 1'b1;
          end else if (!final_e) begin
            b_d  = e_q + IW'(1);
            e_d  = e_q + IW'(1);
            z_d  = '0;
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // An empty walk arrives here with done low and spends one cycle raising it.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    addr_d     = load ? addr_of(e_d, z_d) : addr_q;
    row_last_d = load ? (tbl_last_q[e_d] || is_final(e_d, num_d)) : row_last_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      e_q        <= '0;
      b_q        <= '0;
      z_q        <= '0;
      num_q      <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      row_last_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      b_q        <= b_d;
      z_q        <= z_d;
      num_q      <= num_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      row_last_q <= row_last_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_addr       = addr_q;
  assign o_addr_valid = valid_q;
  assign o_row_last   = row_last_q;
  assign o_done       = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_ldpc_addr_gen.sv
// Bench for ldpc_addr_gen: a Z=4 instance and a Z=3 instance share all inputs except start,
// checked every cycle against a queue built by walking a shadow copy of the table.
module tb_ldpc_addr_gen;

  localparam int COLS = 4;
  localparam int MAXE = 8;
  localparam int IW   = 3;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_wr;
  logic [IW-1:0] tbl_idx;
  logic [1:0]    tbl_col;
  logic [1:0]    tbl_shift;
  logic          tbl_last;
  logic [IW:0]   num;
  logic          start;
  logic          start_b;
  logic          ready;

  logic          busy_a, valid_a, rl_a, done_a;
  logic [AW-1:0] addr_a;
  logic          busy_b, valid_b, rl_b, done_b;
  logic [AW-1:0] addr_b;

  ldpc_addr_gen #(.Z(4), .COLS(COLS), .MAX_ENTRIES(MAXE), .ADDR_W(AW)) u_a (
    .i_clock(clk), .i_reset(rst), .i_tbl_wr(tbl_wr), .i_tbl_idx(tbl_idx),
    .i_tbl_col(tbl_col), .i_tbl_shift(tbl_shift), .i_tbl_last(tbl_last),
    .i_num_entries(num), .i_start(start), .o_busy(busy_a), .o_addr(addr_a),
    .o_addr_valid(valid_a), .i_addr_ready(ready), .o_row_last(rl_a), .o_done(done_a)
  );

  ldpc_addr_gen #(.Z(3), .COLS(COLS), .MAX_ENTRIES(MAXE), .ADDR_W(AW)) u_b (
    .i_clock(clk), .i_reset(rst), .i_tbl_wr(tbl_wr), .i_tbl_idx(tbl_idx),
    .i_tbl_col(tbl_col), .i_tbl_shift(tbl_shift), .i_tbl_last(tbl_last),
    .i_num_entries(num), .i_start(start_b), .o_busy(busy_b), .o_addr(addr_b),
    .o_addr_valid(valid_b), .i_addr_ready(ready), .o_row_last(rl_b), .o_done(done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected queues hold {row_last, addr}.
  logic [4:0] qa[$];
  logic [4:0] qb[$];

  int m_col  [MAXE];
  int m_sh   [MAXE];
  bit m_last [MAXE];

  int cyc = 0;
  int done_at [2] = '{-100, -100};
  int start_cyc [2] = '{0, 0};
  bit first_pending [2] = '{0, 0};
  bit done_seen [2] = '{0, 0};
  bit prev_stall [2] = '{0, 0};
  logic [AW-1:0] prev_addr [2];
  logic prev_rl [2];
  int rdy_mode = 0;
  int rdy_idx = 0;

  int lit_a  [12] = '{5, 12, 6, 13, 7, 14, 4, 15, 3, 0, 1, 2};
  int lit_rl [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1};
  int lit_b  [3]  = '{8, 6, 7};

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Reference walk: layers in table order, each layer swept z-major over its entries.
  function automatic void build(int k, int n);
    int zk, b, en;
    logic rl_bit;
    logic [3:0] a;
    zk = (k == 0) ? 4 : 3;
    if (k == 0) qa.delete(); else qb.delete();
    b = 0;
    while (b < n) begin
      en = b;
      while (!m_last[en] && en < n - 1) en++;
      for (int z = 0; z < zk; z++) begin
        for (int e = b; e <= en; e++) begin
          rl_bit = (e == en);
          a = 4'(m_col[e] * zk + (z + m_sh[e]) % zk);
          if (k == 0) qa.push_back({rl_bit, a}); else qb.push_back({rl_bit, a});
        end
      end
      b = en + 1;
    end
  endfunction

  always @(negedge clk) begin : compare
    logic v [2];
    logic r [2];
    logic d [2];
    logic bz [2];
    logic [AW-1:0] a [2];
    logic [4:0] f;
    bit nr;
    int qs;
    cyc++;
    v[0] = valid_a; v[1] = valid_b;
    r[0] = rl_a;    r[1] = rl_b;
    d[0] = done_a;  d[1] = done_b;
    bz[0] = busy_a; bz[1] = busy_b;
    a[0] = addr_a;  a[1] = addr_b;
    if (rdy_mode == 0) nr = 1'b1;
    else begin
      nr = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
      rdy_idx++;
    end
    ready = nr;
    if (rst) begin
      prev_stall[0] = 0;
      prev_stall[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        check("done", k, d[k], cyc == done_at[k]);
        if (d[k] === 1'b1) done_seen[k] = 1;
        if (cyc == done_at[k]) check("busy_at_done", k, bz[k], 1);
        if (cyc == done_at[k] + 1) check("busy_after_done", k, bz[k], 0);
        if (prev_stall[k]) begin
          check("stall_addr", k, a[k], prev_addr[k]);
          check("stall_row_last", k, r[k], prev_rl[k]);
        end
        qs = (k == 0) ? qa.size() : qb.size();
        if (v[k] === 1'b1) begin
          if (first_pending[k]) begin
            check("first_valid_cycle", k, cyc, start_cyc[k] + 1);
            first_pending[k] = 0;
          end
          if (qs == 0) check("unexpected_valid", k, v[k], 0);
          else begin
            f = (k == 0) ? qa[0] : qb[0];
            check("addr", k, a[k], f[3:0]);
            check("row_last", k, r[k], f[4]);
            if (nr) begin
              if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
              if (qs == 1) done_at[k] = cyc + 1;
            end
          end
        end else if (qs > 0 && !first_pending[k]) begin
          check("valid_held", k, v[k], 1);
        end
        prev_stall[k] = (v[k] === 1'b1) && !nr;
        prev_addr[k]  = a[k];
        prev_rl[k]    = r[k];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(int idx, int col, int sh, bit last, bit to_model);
    tbl_wr = 1'b1; tbl_idx = IW'(idx); tbl_col = 2'(col); tbl_shift = 2'(sh); tbl_last = last;
    tick();
    tbl_wr = 1'b0;
    if (to_model) begin
      m_col[idx] = col; m_sh[idx] = sh; m_last[idx] = last;
    end
  endtask

  task automatic load_tbl1();
    wr(0, 1, 1, 0, 1);
    wr(1, 3, 0, 1, 1);
    wr(2, 0, 3, 1, 1);
  endtask

  task automatic start_walk(int n, bit use_b);
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || use_b) begin
        build(k, n);
        first_pending[k] = (n > 0);
        start_cyc[k] = cyc;
        done_seen[k] = 0;
        if (n == 0) done_at[k] = cyc + 2;
      end
    end
    num = 4'(n); start = 1'b1; start_b = use_b;
    tick();
    start = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(bit use_b);
    int i;
    i = 0;
    while (!(done_seen[0] && (!use_b || done_seen[1])) && i < 400) begin
      tick();
      i++;
    end
    check("walk_done", 0, done_seen[0], 1);
    check("all_addr_delivered", 0, qa.size(), 0);
    if (use_b) begin
      check("walk_done", 1, done_seen[1], 1);
      check("all_addr_delivered", 1, qb.size(), 0);
    end
    tick();
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b1; tbl_wr = 1'b0; tbl_idx = '0; tbl_col = '0; tbl_shift = '0; tbl_last = 1'b0;
    num = '0; start = 1'b0; start_b = 1'b0; ready = 1'b1;
    tick();
    check("reset_addr", 0, addr_a, 0);
    check("reset_valid", 0, valid_a, 0);
    check("reset_row_last", 0, rl_a, 0);
    check("reset_done", 0, done_a, 0);
    check("reset_busy", 0, busy_a, 0);
    rst = 1'b0;
    tick();

    load_tbl1();
    build(0, 3);
    check("model_len", 0, qa.size(), 12);
    for (int j = 0; j < 12; j++) begin
      check("model_addr", 0, qa[j][3:0], lit_a[j]);
      check("model_row_last", 0, qa[j][4], lit_rl[j]);
    end

    start_walk(3, 0);
    wait_done(0);

    rdy_mode = 1; rdy_idx = 0;
    start_walk(3, 0);
    wait_done(0);
    rdy_mode = 0;

    start_walk(0, 0);
    wait_done(0);

    wr(0, 2, 2, 1, 1);
    build(1, 1);
    check("model_len", 1, qb.size(), 3);
    for (int j = 0; j < 3; j++) begin
      check("model_addr", 1, qb[j][3:0], lit_b[j]);
      check("model_row_last", 1, qb[j][4], 1);
    end
    start_walk(1, 1);
    wait_done(1);

    load_tbl1();
    start_walk(3, 0);
    i = 0;
    while (qa.size() > 8 && i < 200) begin tick(); i++; end
    tick();
    check("fifth_addr", 0, addr_a, 7);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_addr", 0, addr_a, 0);
    check("async_reset_valid", 0, valid_a, 0);
    check("async_reset_row_last", 0, rl_a, 0);
    check("async_reset_done", 0, done_a, 0);
    check("async_reset_busy", 0, busy_a, 0);
    qa.delete();
    first_pending[0] = 0;
    done_at[0] = -100;
    tick();
    rst = 1'b0;
    tick();
    tick();
    start_walk(3, 0);
    wait_done(0);

    start_walk(3, 0);
    i = 0;
    while (qa.size() > 6 && i < 200) begin tick(); i++; end
    wr(1, 2, 1, 1, 0);
    num = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0);

    wr(1, 2, 1, 1, 1);
    start_walk(3, 0);
    wait_done(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
